level_cross_dispatcher: RTL and testbench

- Upstream neighbour of the level generator.
- Accepts a stream of signed 16-bit samples and compares each one against the current level limits fed back from the level generator's buff_limits.
- Emits one dispatch beat per level crossing (with direction) to drive the generator's disp_* inputs.
- A sample spanning several levels is serialised into several crossings, with a stall after each until the fed-back limits settle.

---
 rtl/level_cross_dispatcher.sv | 152 +++++++++++++++
 tb/tb_level_cross_dispatcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_cross_dispatcher.sv
// Level-crossing dispatcher: serialises each sample's level crossings into disp beats for the level generator.
// Optional statistics outputs are enabled with LEVEL_CROSS_DISPATCHER_STATS_EN.
//
// state   | meaning
// STARTUP | wait for fed-back limits to become valid after reset
// IDLE    | ready for a new sample
// CHECK   | compare latched sample against current limits
// WAIT    | let the limits settle after a crossing beat
module level_cross_dispatcher #(
  parameter int LIMITS_LATENCY = 2,
  parameter int MAX_CROSSINGS  = 31
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [15:0] i_in_sample,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_lvl_limits,
  output logic        o_disp_valid,
  output logic        o_disp_new_sample,
  output logic        o_disp_cross_dir,
  output logic [15:0] o_disp_sample,
  output logic        o_disp_trunc
`ifdef LEVEL_CROSS_DISPATCHER_STATS_EN
  ,
  output logic [31:0] o_stat_crossings,
  output logic [15:0] o_stat_trunc
`endif
);

  localparam int WAIT_W = $clog2(LIMITS_LATENCY + 1);
  localparam int CNT_W  = $clog2(MAX_CROSSINGS + 1);
  localparam logic [WAIT_W-1:0] LAT      = WAIT_W'(LIMITS_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_CROSSINGS);

  typedef enum logic [1:0] {S_STARTUP, S_IDLE, S_CHECK, S_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic signed [15:0] r_sample;
  logic signed [15:0] w_upper, w_lower;
  logic               w_up, w_down;
  logic               w_latch, w_beat, w_new, w_dir, w_trunc;
  logic               r_disp_valid, r_disp_new, r_disp_dir, r_disp_trunc;
  logic [15:0]        r_disp_sample;

  assign w_upper = i_lvl_limits[31:16];
  assign w_lower = i_lvl_limits[15:0];
  // 0x7FFF / 0x8000 mark the outermost levels and never count as a crossing
  assign w_up    = (r_sample >= w_upper) && (w_upper != 16'h7FFF);
  assign w_down  = (r_sample < w_lower) && (w_lower != 16'h8000) && !w_up;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_beat      = 1'b0;
    w_new       = 1'b0;
    w_dir       = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      S_STARTUP: begin
        if (r_wait == WAIT_ONE) w_state_nxt = S_IDLE;
        else                    w_wait_nxt  = r_wait - WAIT_ONE;
      end
      S_IDLE: begin
        if (i_in_valid) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_up || w_down) begin
          if (r_cnt == CNT_MAX) begin
            w_trunc     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat      = 1'b1;
            w_new       = 1'b1;
            w_dir       = w_up;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_wait_nxt  = LAT;
            w_state_nxt = S_WAIT;
          end
        end else begin
          // a sample with no crossing still produces one non-crossing beat
          w_beat      = (r_cnt == '0);
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait == WAIT_ONE) w_state_nxt = S_CHECK;
        else                    w_wait_nxt  = r_wait - WAIT_ONE;
      end
      default: w_state_nxt = S_STARTUP;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_STARTUP;
      r_wait        <= LAT;
      r_cnt         <= '0;
      r_sample      <= '0;
      r_disp_valid  <= 1'b0;
      r_disp_new    <= 1'b0;
      r_disp_dir    <= 1'b0;
      r_disp_trunc  <= 1'b0;
      r_disp_sample <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait       <= w_wait_nxt;
      r_cnt        <= w_cnt_nxt;
      r_disp_valid <= w_beat;
      r_disp_new   <= w_new;
      r_disp_dir   <= w_dir;
      r_disp_trunc <= w_trunc;
      if (w_latch) r_sample      <= i_in_sample;
      if (w_beat)  r_disp_sample <= r_sample;
    end
  end

  assign o_in_ready        = (r_state == S_IDLE);
  assign o_disp_valid      = r_disp_valid;
  assign o_disp_new_sample = r_disp_new;
  assign o_disp_cross_dir  = r_disp_dir;
  assign o_disp_sample     = r_disp_sample;
  assign o_disp_trunc      = r_disp_trunc;

`ifdef LEVEL_CROSS_DISPATCHER_STATS_EN
  logic [31:0] r_stat_crossings;
  logic [15:0] r_stat_trunc;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stat_crossings <= '0;
      r_stat_trunc     <= '0;
    end else begin
      if (w_beat && w_new && (r_stat_crossings != '1)) r_stat_crossings <= r_stat_crossings + 32'd1;
      if (w_trunc && (r_stat_trunc != '1))             r_stat_trunc     <= r_stat_trunc + 16'd1;
    end
  end

  assign o_stat_crossings = r_stat_crossings;
  assign o_stat_trunc     = r_stat_trunc;
`endif

endmodule

// File: tb/tb_level_cross_dispatcher.sv
// Directed bench for level_cross_dispatcher with a behavioural 20-level generator fed back into the limits.
// dut0 uses the default crossing limit, dut1 is built with MAX_CROSSINGS = 2.
module tb_level_cross_dispatcher;

  typedef struct packed {
    int          t;
    logic        nw;
    logic        dir;
    logic [15:0] s;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_sample;
  logic        v0, v1;
  logic        rdy0, rdy1;
  logic [31:0] lim0, lim1;
  logic        dv0, dn0, dd0, dt0, dv1, dn1, dd1, dt1;
  logic [15:0] ds0, ds1;
  int          lvl0, lvl1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          junk = 0;
  beat_t       q0[$], q1[$];
  int          tq0[$], tq1[$];
`ifdef LEVEL_CROSS_DISPATCHER_STATS_EN
  logic [31:0] sc0, sc1;
  logic [15:0] st0, st1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  level_cross_dispatcher u_dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_in_sample(in_sample), .i_in_valid(v0),
    .o_in_ready(rdy0), .i_lvl_limits(lim0), .o_disp_valid(dv0), .o_disp_new_sample(dn0),
    .o_disp_cross_dir(dd0), .o_disp_sample(ds0), .o_disp_trunc(dt0)
`ifdef LEVEL_CROSS_DISPATCHER_STATS_EN
    , .o_stat_crossings(sc0), .o_stat_trunc(st0)
`endif
  );

  level_cross_dispatcher #(.LIMITS_LATENCY(2), .MAX_CROSSINGS(2)) u_dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_in_sample(in_sample), .i_in_valid(v1),
    .o_in_ready(rdy1), .i_lvl_limits(lim1), .o_disp_valid(dv1), .o_disp_new_sample(dn1),
    .o_disp_cross_dir(dd1), .o_disp_sample(ds1), .o_disp_trunc(dt1)
`ifdef LEVEL_CROSS_DISPATCHER_STATS_EN
    , .o_stat_crossings(sc1), .o_stat_trunc(st1)
`endif
  );

  // Boundary between level k-1 and k: floor((k-10)*65536/20 + 65536/40)
  function automatic logic [15:0] bnd(input int k);
    int num, q;
    num = (k - 10) * 32768 + 16384;
    if (num >= 0) q = num / 10;
    else          q = -((-num + 9) / 10);
    return q[15:0];
  endfunction

  function automatic logic [31:0] limits_of(input int k);
    logic [15:0] up, lo;
    up = (k == 19) ? 16'h7FFF : bnd(k + 1);
    lo = (k == 0)  ? 16'h8000 : bnd(k);
    return {up, lo};
  endfunction

  function automatic int next_lvl(input int k, input logic dir);
    if (dir) return (k < 19) ? k + 1 : k;
    return (k > 0) ? k - 1 : k;
  endfunction

  // Generator model: level moves one cycle after a beat, limits one cycle after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl0 <= 9; lim0 <= '0; lvl1 <= 9; lim1 <= '0;
    end else begin
      if (dv0 && dn0) lvl0 <= next_lvl(lvl0, dd0);
      if (dv1 && dn1) lvl1 <= next_lvl(lvl1, dd1);
      lim0 <= limits_of(lvl0);
      lim1 <= limits_of(lvl1);
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (dv0) begin b.t = cyc; b.nw = dn0; b.dir = dd0; b.s = ds0; q0.push_back(b); end
    if (dv1) begin b.t = cyc; b.nw = dn1; b.dir = dd1; b.s = ds1; q1.push_back(b); end
    if (dt0) tq0.push_back(cyc);
    if (dt1) tq1.push_back(cyc);
    if ((!dv0 && (dn0 || dd0)) || (!dn0 && dd0)) junk++;
    if ((!dv1 && (dn1 || dd1)) || (!dn1 && dd1)) junk++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send(input int g, input logic [15:0] s, output int t);
    int k;
    k = 0;
    @(negedge clk);
    in_sample = s;
    if (g == 0) v0 = 1'b1; else v1 = 1'b1;
    while (!((g == 0) ? rdy0 : rdy1) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("accept_in_time", 32'(k < 60), 32'd1);
    t = cyc;
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic chk_beats0(input string tag, input int t, input int n, input logic nw,
                            input logic dir, input logic [15:0] s);
    chk({tag, "_count"}, q0.size(), n);
    for (int i = 0; i < n && i < q0.size(); i++) begin
      chk({tag, "_cycle"}, q0[i].t, t + 2 + 3 * i);
      chk({tag, "_kind"}, {q0[i].nw, q0[i].dir}, {nw, dir});
      chk({tag, "_sample"}, q0[i].s, s);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    q0.delete(); q1.delete(); tq0.delete(); tq1.delete();
  endtask

  initial begin
    int r, t;
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b0; in_sample = 16'h0000;

    // reset state, in_valid already held high
    @(negedge clk); #1;
    chk("rst_outputs", {rdy0, dv0, dn0, dd0, dt0, ds0}, '0);
    chk("rst_ready1", 32'(rdy1), 32'd0);

    // startup: ready low for two cycles, then zero sample gives a non-crossing beat
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    #1 chk("startup_rdy_c0", 32'(rdy0), 32'd0);
    @(negedge clk); chk("startup_rdy_c1", 32'(rdy0), 32'd0);
    @(negedge clk); chk("startup_rdy_c2", 32'(rdy0), 32'd1);
    t = cyc;
    @(negedge clk); v0 = 1'b0;
    chk("check_rdy", 32'(rdy0), 32'd0);
    wait_cyc(t + 2); chk("zero_rdy_back", 32'(rdy0), 32'd1);
    wait_cyc(t + 8);
    chk_beats0("zero", t, 1, 1'b0, 1'b0, 16'h0000);

    // two upward crossings from level 9
    q0.delete();
    send(0, 16'h1400, t);
    wait_cyc(t + 7); chk("up2_rdy_low", 32'(rdy0), 32'd0);
    wait_cyc(t + 8); chk("up2_rdy_back", 32'(rdy0), 32'd1);
    wait_cyc(t + 15);
    chk_beats0("up2", t, 2, 1'b1, 1'b1, 16'h1400);

    // nine downward crossings to the bottom sentinel
    do_reset();
    send(0, 16'h8100, t);
    wait_cyc(t + 40);
    chk_beats0("down9", t, 9, 1'b1, 1'b0, 16'h8100);
    chk("down9_no_trunc", tq0.size(), 0);

    // ten upward crossings to the top sentinel, then a repeat gives no crossing
    do_reset();
    send(0, 16'h7FFF, t);
    wait_cyc(t + 40);
    chk_beats0("up10", t, 10, 1'b1, 1'b1, 16'h7FFF);
    q0.delete();
    send(0, 16'h7FFF, t);
    wait_cyc(t + 10);
    chk_beats0("top_hold", t, 1, 1'b0, 1'b0, 16'h7FFF);

    // truncation on dut1 (limit 2) with four pending crossings
    send(1, 16'h3000, t);
    wait_cyc(t + 7); chk("trunc_rdy_low", 32'(rdy1), 32'd0);
    wait_cyc(t + 8); chk("trunc_rdy_back", 32'(rdy1), 32'd1);
    wait_cyc(t + 15);
    chk("trunc_beats", q1.size(), 2);
    if (q1.size() == 2) begin
      chk("trunc_beat0", {q1[0].t, q1[0].nw, q1[0].dir, q1[0].s}, {t + 2, 1'b1, 1'b1, 16'h3000});
      chk("trunc_beat1", {q1[1].t, q1[1].nw, q1[1].dir, q1[1].s}, {t + 5, 1'b1, 1'b1, 16'h3000});
    end
    chk("trunc_pulses", tq1.size(), 1);
    if (tq1.size() == 1) chk("trunc_cycle", tq1[0], t + 8);
    q1.delete(); tq1.delete();
    send(1, 16'h3000, t);
    wait_cyc(t + 15);
    chk("after_trunc_beats", q1.size(), 2);
    chk("after_trunc_no_pulse", tq1.size(), 0);
    if (q1.size() == 2) chk("after_trunc_cycle", q1[1].t, t + 5);

    // reset during WAIT abandons the sample
    do_reset();
    send(0, 16'h8100, t);
    wait_cyc(t + 3);
    chk("pre_reset_beat", q0.size(), 1);
    rst_n = 1'b0;
    #1 chk("midrst_outputs", {rdy0, dv0, dn0, dd0, dt0, ds0}, '0);
    @(negedge clk); @(negedge clk);
    q0.delete(); tq0.delete();
    rst_n = 1'b1;
    r = cyc;
    #1 chk("midrst_startup", 32'(rdy0), 32'd0);
    wait_cyc(r + 30);
    chk("midrst_no_beats", q0.size(), 0);
    chk("midrst_no_trunc", tq0.size(), 0);
    chk("midrst_rdy", 32'(rdy0), 32'd1);

    chk("pulse_hygiene", junk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
